// File: rtl/regfile_arbiter.sv
// Round-robin sequencer granting NREQ requesters single-word access to a shared 2^ADDR_W x DATA_W register array.
// Optional MEM_ARB_LOCK_EN adds a per-requester lock input that lets the current winner keep the array.
module regfile_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               lockHold_q, lockHold_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               memWr;

  logic [IDX_W-1:0]   pick;
  logic               pickValid;
  logic [IDX_W:0]     rrIdx;

  logic [ADDR_W-1:0]  addrArr  [NREQ];
  logic [DATA_W-1:0]  wdataArr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addrArr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdataArr[g] = wdata[g*DATA_W +: DATA_W];
  end

  // Descending scan so the requester closest after last is the final (winning) assignment.
  always_comb begin
    pick      = last_q;
    pickValid = 1'b0;
    rrIdx     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      rrIdx = {1'b0, last_q} + (IDX_W+1)'(i);
      if (rrIdx >= (IDX_W+1)'(NREQ)) rrIdx = rrIdx - (IDX_W+1)'(NREQ);
      if (req[rrIdx[IDX_W-1:0]]) begin
        pick      = rrIdx[IDX_W-1:0];
        pickValid = 1'b1;
      end
    end
`ifdef MEM_ARB_LOCK_EN
    if (lockHold_q && req[win_q]) begin
      pick      = win_q;
      pickValid = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    gnt_d      = '0;
    ack_d      = '0;
    rdata_d    = rdata_q;
    lockHold_d = 1'b0;
    memWr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d     = ACCESS;
          win_d       = pick;
          we_d        = we[pick];
          addr_d      = addrArr[pick];
          wdata_d     = wdataArr[pick];
          gnt_d[pick] = 1'b1;
        end
      end
      ACCESS: begin
        state_d      = RESP;
        ack_d[win_q] = 1'b1;
        if (we_q) memWr = 1'b1;
        else      rdata_d = mem_q[addr_q];
      end
      RESP: begin
        state_d = IDLE;
        // Re-recording the same winner keeps rotation anchored during a lock chain.
        last_d  = win_q;
`ifdef MEM_ARB_LOCK_EN
        lockHold_d = lock[win_q];
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NREQ-1);
      win_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      lockHold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      lockHold_q <= lockHold_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (memWr) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized self-checking bench for regfile_arbiter against a transaction-level model.
// Build with MEM_ARB_LOCK_EN defined to also exercise the lock input.
module tb_regfile_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;

  int testCount;
  int failCount;

  logic [DATA_W-1:0] modelMem [32];
  logic [DATA_W-1:0] modelRdata;
  int                modelLast;
  bit                modelLockHold;

  regfile_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
`ifdef MEM_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .ack   (ack),
    .rdata (rdata),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) modelMem[i] = '0;
    modelRdata    = '0;
    modelLast     = NREQ - 1;
    modelLockHold = 1'b0;
  endtask

  // Winner: first requester after the previous winner, unless a lock holds the previous one.
  function automatic int pickWinner(input logic [NREQ-1:0] r);
`ifdef MEM_ARB_LOCK_EN
    if (modelLockHold && r[modelLast]) return modelLast;
`endif
    for (int i = 1; i <= NREQ; i++) begin
      if (r[(modelLast + i) % NREQ]) return (modelLast + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic doReset();
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    @(posedge clk); #1;
    modelReset();
    checkOutput("rstGnt", 32'(gnt), 32'(0));
    checkOutput("rstRdata", 32'(rdata), 32'(0));
    rst = 1'b0;
  endtask

  // One full arbitration attempt: drives inputs, then checks the 3-cycle transaction or an idle cycle.
  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] wv,
                               input logic [NREQ*ADDR_W-1:0] a, input logic [NREQ*DATA_W-1:0] d,
                               input logic [NREQ-1:0] lk);
    int                w;
    logic [NREQ-1:0]   oh;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] wd;
    req = r; we = wv; addr = a; wdata = d; lock = lk;
    w = pickWinner(r);
    modelLockHold = 1'b0;
    @(posedge clk); #1;
    if (w < 0) begin
      checkOutput("idleGnt", 32'(gnt), 32'(0));
      checkOutput("idleAck", 32'(ack), 32'(0));
      checkOutput("idleBusy", 32'(busy), 32'(0));
      checkOutput("idleRdata", 32'(rdata), 32'(modelRdata));
      return;
    end
    oh = NREQ'(1) << w;
    ad = a[w*ADDR_W +: ADDR_W];
    wd = d[w*DATA_W +: DATA_W];
    checkOutput("gnt", 32'(gnt), 32'(oh));
    checkOutput("accAck", 32'(ack), 32'(0));
    checkOutput("accBusy", 32'(busy), 32'(1));
    req   = NREQ'($urandom);
    we    = NREQ'($urandom);
    addr  = (NREQ*ADDR_W)'($urandom);
    wdata = (NREQ*DATA_W)'($urandom);
    @(posedge clk); #1;
    if (wv[w]) modelMem[ad] = wd;
    else       modelRdata   = modelMem[ad];
    checkOutput("ack", 32'(ack), 32'(oh));
    checkOutput("respGnt", 32'(gnt), 32'(0));
    checkOutput("rdata", 32'(rdata), 32'(modelRdata));
    checkOutput("respBusy", 32'(busy), 32'(1));
    @(posedge clk); #1;
    checkOutput("doneAck", 32'(ack), 32'(0));
    checkOutput("doneBusy", 32'(busy), 32'(0));
    modelLast     = w;
    modelLockHold = lk[w];
    req = '0;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; lock = '0;
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAck", 32'(ack), 32'(0));
    checkOutput("rstBusy", 32'(busy), 32'(0));
    rst = 1'b0;
    repeat (10) applyStimulus('0, '0, '0, '0, '0);

    // Requester 2 writes then reads addr 5, then reads unwritten addr 6.
    applyStimulus(4'b0100, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, {8'h00, 8'hA5, 8'h00, 8'h00}, '0);
    applyStimulus(4'b0100, 4'b0000, {5'd0, 5'd5, 5'd0, 5'd0}, '0, '0);
    checkOutput("rdA5", 32'(modelRdata), 32'(8'hA5));
    applyStimulus(4'b0100, 4'b0000, {5'd0, 5'd6, 5'd0, 5'd0}, '0, '0);

    doReset();
    for (int i = 0; i < 12; i++)
      applyStimulus(4'b1111, NREQ'($urandom), (NREQ*ADDR_W)'($urandom), (NREQ*DATA_W)'($urandom), '0);

    doReset();
    applyStimulus(4'b0100, 4'b0000, '0, '0, '0);
    applyStimulus(4'b0011, 4'b0000, '0, '0, '0);
    applyStimulus(4'b0010, 4'b0000, '0, '0, '0);

    // Reset arrives during the ACCESS cycle of a write: no commit, no ack.
    req = 4'b0010; we = 4'b0010;
    addr  = {5'd0, 5'd0, 5'd31, 5'd0};
    wdata = {8'h00, 8'h00, 8'h3C, 8'h00};
    @(posedge clk); #1;
    checkOutput("midGnt", 32'(gnt), 32'(4'b0010));
    #2 rst = 1'b1;
    #1;
    checkOutput("midAck", 32'(ack), 32'(0));
    checkOutput("midGntClr", 32'(gnt), 32'(0));
    checkOutput("midBusy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    checkOutput("midAck2", 32'(ack), 32'(0));
    modelReset();
    rst = 1'b0; req = '0;
    applyStimulus(4'b0010, 4'b0000, {5'd0, 5'd0, 5'd31, 5'd0}, '0, '0);

`ifdef MEM_ARB_LOCK_EN
    doReset();
    applyStimulus(4'b0011, 4'b0000, '0, '0, 4'b0001);
    applyStimulus(4'b0011, 4'b0000, '0, '0, 4'b0001);
    applyStimulus(4'b0011, 4'b0000, '0, '0, 4'b0000);
    applyStimulus(4'b0011, 4'b0000, '0, '0, 4'b0000);
    checkOutput("lockRelease", 32'(modelLast), 32'(1));
`endif

    doReset();
    for (int i = 0; i < 200; i++) begin
      logic [NREQ-1:0] r;
      r = ($urandom_range(0, 7) == 0) ? '0 : NREQ'($urandom);
      applyStimulus(r, NREQ'($urandom), (NREQ*ADDR_W)'($urandom_range(0, 1) ? $urandom_range(0, 3) * 32'h4210 : $urandom),
                    (NREQ*DATA_W)'($urandom), NREQ'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
